// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg
//  Shared definitions for the AHB-to-APB bridge sequencer: FSM state
//  encoding, AHB HTRANS codes, default slave address tags and the
//  AHB OKAY response code.
package apb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WWAIT   = 3'd1,
        ST_WRITE   = 3'd2,
        ST_WENABLE = 3'd3,
        ST_READ    = 3'd4,
        ST_RENABLE = 3'd5
    } apb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Width of the slave-select field at the top of the address.
    localparam int TAG_W = 6;

    localparam logic [TAG_W-1:0] SLV0_TAG_DEF = 6'h20;
    localparam logic [TAG_W-1:0] SLV1_TAG_DEF = 6'h21;
    localparam logic [TAG_W-1:0] SLV2_TAG_DEF = 6'h22;

    localparam logic [1:0] HRESP_OKAY = 2'b00;

endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode
//  Combinational address decoder for the AHB-to-APB bridge. Flags a valid
//  transfer (bridge selected, NONSEQ/SEQ, mapped address) and produces the
//  one-hot APB slave select from the tag field haddr[SEL_LSB +: TAG_W].
// Ports
//  haddr   in   ADDR_W  AHB address-phase address
//  hsel    in   1       bridge selected by AHB decoder
//  htrans  in   2       AHB transfer type
//  valid   out  1       transfer should be taken
//  sel     out  3       one-hot slave select (0 when unmapped)
module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter int               SEL_LSB  = 26,
    parameter logic [TAG_W-1:0] SLV0_TAG = SLV0_TAG_DEF,
    parameter logic [TAG_W-1:0] SLV1_TAG = SLV1_TAG_DEF,
    parameter logic [TAG_W-1:0] SLV2_TAG = SLV2_TAG_DEF
) (
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    output logic              valid,
    output logic [2:0]        sel
);

    logic [TAG_W-1:0] tag;
    logic             unused_low_addr;

    assign tag = haddr[SEL_LSB +: TAG_W];

    // Offset bits inside a slave window play no part in decoding.
    assign unused_low_addr = ^haddr[SEL_LSB-1:0];

    always_comb begin
        sel = 3'b000;
        if (tag == SLV0_TAG) begin
            sel = 3'b001;
        end else if (tag == SLV1_TAG) begin
            sel = 3'b010;
        end else if (tag == SLV2_TAG) begin
            sel = 3'b100;
        end
        valid = hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) && (sel != 3'b000);
    end

endmodule

// File: rtl/apb_controller.sv
// apb_controller
//  AHB-to-APB bridge sequencer. Takes single AHB transfers, decodes them to
//  one of three APB slaves, runs the APB setup and access phases and stalls
//  AHB through hreadyout until the APB access completes.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | no transfer, hreadyout=1, waiting for a valid address phase
//  ST_WWAIT   | write accepted, capturing hwdata from the AHB data phase
//  ST_WRITE   | APB write setup phase (psel on, penable off)
//  ST_WENABLE | APB write access phase, held while pready=0
//  ST_READ    | APB read setup phase
//  ST_RENABLE | APB read access phase, hrdata loaded on completion
//
// Ports
//  hclk, hreset            clock, synchronous active-high reset
//  hsel, htrans, hwrite    AHB address-phase control
//  haddr, hwdata           AHB address and write data
//  prdata, pready          APB read data and ready
//  hreadyout, hresp, hrdata  AHB response
//  pwrite, penable, pselx, paddr, pwdata  registered APB request
module apb_controller
    import apb_bridge_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter int               DATA_W   = 32,
    parameter int               SEL_LSB  = 26,
    parameter logic [TAG_W-1:0] SLV0_TAG = SLV0_TAG_DEF,
    parameter logic [TAG_W-1:0] SLV1_TAG = SLV1_TAG_DEF,
    parameter logic [TAG_W-1:0] SLV2_TAG = SLV2_TAG_DEF
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    output logic              hreadyout,
    output logic [1:0]        hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic              pwrite,
    output logic              penable,
    output logic [2:0]        pselx,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata
);

    apb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [2:0]        sel_q, sel_d;
    logic              capture;
    logic              dec_valid;
    logic [2:0]        dec_sel;

    apb_addr_decode #(
        .ADDR_W   (ADDR_W),
        .SEL_LSB  (SEL_LSB),
        .SLV0_TAG (SLV0_TAG),
        .SLV1_TAG (SLV1_TAG),
        .SLV2_TAG (SLV2_TAG)
    ) u_decode (
        .haddr  (haddr),
        .hsel   (hsel),
        .htrans (htrans),
        .valid  (dec_valid),
        .sel    (dec_sel)
    );

    assign hresp = HRESP_OKAY;

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        hreadyout = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (dec_valid) begin
                    capture = 1'b1;
                    state_d = hwrite ? ST_WWAIT : ST_READ;
                end
            end
            ST_WWAIT: begin
                hreadyout = 1'b0;
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                hreadyout = 1'b0;
                state_d   = ST_WENABLE;
            end
            ST_READ: begin
                hreadyout = 1'b0;
                state_d   = ST_RENABLE;
            end
            ST_WENABLE, ST_RENABLE: begin
                // Only combinational input-to-output path in the block.
                hreadyout = pready;
                if (pready) begin
                    if (dec_valid) begin
                        capture = 1'b1;
                        state_d = hwrite ? ST_WWAIT : ST_READ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A read goes straight from capture to setup, so the setup-phase
        // registers must see the address being captured on the same edge.
        addr_d  = capture ? haddr   : addr_q;
        write_d = capture ? hwrite  : write_q;
        sel_d   = capture ? dec_sel : sel_q;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            sel_q   <= 3'b000;
            pselx   <= 3'b000;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            hrdata  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            sel_q   <= sel_d;

            if (state_q == ST_WWAIT) begin
                pwdata <= hwdata;
            end
            if (state_q == ST_RENABLE && pready) begin
                hrdata <= prdata;
            end

            // APB outputs are loaded from the next state so they change only
            // on clock edges; paddr/pwrite/pwdata keep their last value when idle.
            case (state_d)
                ST_WRITE, ST_READ: begin
                    pselx   <= sel_d;
                    pwrite  <= write_d;
                    paddr   <= addr_d;
                    penable <= 1'b0;
                end
                ST_WENABLE, ST_RENABLE: begin
                    penable <= 1'b1;
                end
                default: begin
                    pselx   <= 3'b000;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_controller.sv
module tb_apb_controller;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        pwrite;
    logic        penable;
    logic [2:0]  pselx;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    always #5 hclk = ~hclk;

    apb_controller dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hsel),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .prdata    (prdata),
        .pready    (pready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .pwrite    (pwrite),
        .penable   (penable),
        .pselx     (pselx),
        .paddr     (paddr),
        .pwdata    (pwdata)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Scoreboard: expected APB setup phases and AHB read data, in order.
    logic [2:0]  exp_sel_q[$];
    logic [31:0] exp_addr_q[$];
    logic        exp_wr_q[$];
    logic [31:0] exp_wd_q[$];
    logic [31:0] exp_rd_q[$];

    // APB slave model: per mapped transfer, wait-state count and read data.
    int          sl_wait_q[$];
    logic [31:0] sl_rd_q[$];
    bit          sl_active = 1'b0;
    int          sl_waits  = 0;
    logic [31:0] sl_rd     = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference address map: three 64 MiB windows starting at 0x8000_0000.
    function automatic logic [2:0] ref_sel(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'h8400_0000) return 3'b001;
        if (a >= 32'h8400_0000 && a < 32'h8800_0000) return 3'b010;
        if (a >= 32'h8800_0000 && a < 32'h8C00_0000) return 3'b100;
        return 3'b000;
    endfunction

    // Slave: decides pready / prdata just after each rising edge.
    always @(posedge hclk) begin
        #1;
        if (penable) begin
            if (!sl_active) begin
                if (sl_wait_q.size() > 0) begin
                    sl_waits = sl_wait_q.pop_front();
                    sl_rd    = sl_rd_q.pop_front();
                end else begin
                    sl_waits = 0;
                    sl_rd    = '0;
                end
                sl_active = 1'b1;
            end
            if (sl_waits > 0) begin
                pready = 1'b0;
                prdata = $urandom;
                sl_waits--;
            end else begin
                pready    = 1'b1;
                prdata    = sl_rd;
                sl_active = 1'b0;
            end
        end else begin
            pready = 1'b1;
        end
    end

    // Monitor: checks every APB setup phase and every completed read.
    bit rd_pending = 1'b0;
    always @(negedge hclk) begin
        if (hreset) begin
            rd_pending = 1'b0;
        end else begin
            if (rd_pending) begin
                if (exp_rd_q.size() == 0) chk("hrdata_unexpected", 32'd1, 32'd0);
                else chk("hrdata", hrdata, exp_rd_q.pop_front());
                rd_pending = 1'b0;
            end
            if (penable && hreadyout && !pwrite) rd_pending = 1'b1;
            if (pselx != 3'b000 && !penable) begin
                if (exp_sel_q.size() == 0) begin
                    chk("setup_unexpected", 32'(pselx), 32'd0);
                end else begin
                    logic [2:0]  es;
                    logic [31:0] ea;
                    logic        ew;
                    logic [31:0] ed;
                    es = exp_sel_q.pop_front();
                    ea = exp_addr_q.pop_front();
                    ew = exp_wr_q.pop_front();
                    ed = exp_wd_q.pop_front();
                    chk("setup_pselx", 32'(pselx), 32'(es));
                    chk("setup_paddr", paddr, ea);
                    chk("setup_pwrite", 32'(pwrite), 32'(ew));
                    if (ew) chk("setup_pwdata", pwdata, ed);
                end
            end
        end
    end

    task automatic idle(input int n);
        hsel   = 1'b0;
        htrans = T_IDLE;
        repeat (n) @(negedge hclk);
    endtask

    // Issue one AHB transfer. Starts and ends on a falling edge where the
    // bridge can accept an address, so consecutive calls are back-to-back.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int waits, input bit take);
        logic [2:0] s;
        bit         mapped;
        bit         done;
        int         lat;
        int         stalls;
        int         v;
        s      = ref_sel(addr);
        mapped = take && (s != 3'b000);
        done   = 1'b0;
        lat    = 1;
        stalls = 0;
        if (take) begin
            hsel   = 1'b1;
            htrans = ($urandom_range(0, 3) == 0) ? T_SEQ : T_NONSEQ;
        end else begin
            v = $urandom_range(0, 2);
            hsel   = (v != 0);
            htrans = (v == 0) ? T_NONSEQ : ((v == 1) ? T_BUSY : T_IDLE);
        end
        hwrite = wr;
        haddr  = addr;
        if (mapped) begin
            exp_sel_q.push_back(s);
            exp_addr_q.push_back(addr);
            exp_wr_q.push_back(wr);
            exp_wd_q.push_back(wd);
            sl_wait_q.push_back(waits);
            sl_rd_q.push_back(rd);
            if (!wr) exp_rd_q.push_back(rd);
        end
        @(posedge hclk);
        #1;
        hsel   = 1'b0;
        htrans = T_IDLE;
        hwrite = 1'($urandom);
        haddr  = $urandom;
        hwdata = wd;
        if (!mapped) begin
            @(negedge hclk);
            chk("notaken_hreadyout", 32'(hreadyout), 32'd1);
            chk("notaken_pselx", 32'(pselx), 32'd0);
            return;
        end
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge hclk);
            lat++;
            if (lat == 2) chk("accept_stall", 32'(hreadyout), 32'd0);
            if (hreadyout) done = 1'b1;
            else if (penable) stalls++;
        end
        chk("completion", 32'(done), 32'd1);
        chk("access_penable", 32'(penable), 32'd1);
        chk("latency", 32'(lat), 32'((wr ? 4 : 3) + waits));
        chk("wait_stalls", 32'(stalls), 32'(waits));
    endtask

    task automatic reset_mid_write();
        bit reached;
        reached = 1'b0;
        hsel   = 1'b1;
        htrans = T_NONSEQ;
        hwrite = 1'b1;
        haddr  = 32'h8400_0100;
        exp_sel_q.push_back(3'b010);
        exp_addr_q.push_back(32'h8400_0100);
        exp_wr_q.push_back(1'b1);
        exp_wd_q.push_back(32'h1234_5678);
        sl_wait_q.push_back(10);
        sl_rd_q.push_back(32'h0);
        @(posedge hclk);
        #1;
        hsel   = 1'b0;
        htrans = T_IDLE;
        hwdata = 32'h1234_5678;
        for (int i = 0; i < 10 && !reached; i++) begin
            @(negedge hclk);
            if (penable) reached = 1'b1;
        end
        chk("rst_reached_enable", 32'(reached), 32'd1);
        hreset = 1'b1;
        sl_wait_q.delete();
        sl_rd_q.delete();
        sl_active = 1'b0;
        sl_waits  = 0;
        @(negedge hclk);
        chk("rst_pselx", 32'(pselx), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_paddr", paddr, 32'd0);
        @(negedge hclk);
        hreset = 1'b0;
        @(negedge hclk);
        chk("post_rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("post_rst_pselx", 32'(pselx), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  tag;
        logic [31:0] r;
        logic [31:0] a;
        hreset = 1'b1;
        hsel   = 1'b0;
        htrans = T_IDLE;
        hwrite = 1'b0;
        haddr  = '0;
        hwdata = '0;
        pready = 1'b1;
        prdata = '0;
        repeat (3) @(negedge hclk);
        chk("init_pselx", 32'(pselx), 32'd0);
        chk("init_penable", 32'(penable), 32'd0);
        chk("init_pwrite", 32'(pwrite), 32'd0);
        chk("init_hreadyout", 32'(hreadyout), 32'd1);
        chk("init_paddr", paddr, 32'd0);
        chk("init_pwdata", pwdata, 32'd0);
        chk("init_hrdata", hrdata, 32'd0);
        chk("init_hresp", 32'(hresp), 32'd0);
        hreset = 1'b0;
        @(negedge hclk);

        xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1'b1);
        idle(1);
        xfer(1'b0, 32'h8400_0004, 32'h0, 32'h0000_0019, 0, 1'b1);
        idle(2);
        xfer(1'b0, 32'h8800_0000, 32'h0, 32'hA5A5_0F0F, 3, 1'b1);
        // read completes with a new write already on the bus
        xfer(1'b0, 32'h8400_0008, 32'h0, 32'h0BAD_F00D, 0, 1'b1);
        xfer(1'b1, 32'h8000_0020, 32'hCAFE_0001, 32'h0, 0, 1'b1);
        idle(1);
        xfer(1'b1, 32'h9000_0000, 32'h1111_2222, 32'h0, 0, 1'b1);
        idle(1);
        reset_mid_write();

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0:       tag = 6'h20;
                1:       tag = 6'h21;
                2:       tag = 6'h22;
                default: tag = 6'($urandom_range(0, 63));
            endcase
            r = $urandom;
            a = {tag, r[25:0]};
            xfer(1'($urandom), a, $urandom, $urandom, $urandom_range(0, 3),
                 $urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        idle(3);
        chk("sb_drain", 32'(exp_sel_q.size() + exp_rd_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
